// File: rtl/line_mem_responder.sv
// line_mem_responder: slow line-granular main memory serving the cache's
// swap-in (line read) and swap-out (line write) requests. One request is
// accepted in IDLE, held in BUSY for LATENCY cycles, committed on the edge
// that enters GNT, and acknowledged with a one-cycle gnt pulse.
module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 10,
  parameter int LATENCY       = 50
) (
  input  logic                clk,
  input  logic                rst,
  output logic                gnt,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  output logic [31:0]         rd_line [1 << LINE_ADDR_LEN],
  input  logic                wr_req,
  input  logic [31:0]         wr_line [1 << LINE_ADDR_LEN]
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int NUM_LINES = 1 << ADDR_LEN;
  // The counter only has to reach LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef logic [31:0] line_t [LINE_SIZE];
  typedef line_t mem_t [NUM_LINES];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GNT  = 2'd2
  } state_t;

  // Power-up image: every word holds its own word address.
  function automatic mem_t mem_init();
    mem_t m;
    for (int a = 0; a < NUM_LINES; a++) begin
      for (int k = 0; k < LINE_SIZE; k++) begin
        m[a][k] = 32'((a << LINE_ADDR_LEN) + k);
      end
    end
    return m;
  endfunction

  // Storage is deliberately outside the reset domain.
  mem_t mem_q = mem_init();

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  line_t               wline_q, wline_d;
  line_t               rd_line_q, rd_line_d;
  logic                gnt_q, gnt_d;
  logic                mem_we_s;

  assign gnt     = gnt_q;
  assign rd_line = rd_line_q;

  // Next-state logic: request capture, latency count and commit decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    rd_line_d = rd_line_q;
    gnt_d     = 1'b0;
    mem_we_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req || rd_req) begin
          // A simultaneous read is dropped in favour of the write.
          addr_d  = addr;
          is_wr_d = wr_req;
          cnt_d   = CNT_W'(0);
          state_d = ST_BUSY;
          if (wr_req) begin
            wline_d = wr_line;
          end else begin
            wline_d = wline_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_GNT;
          gnt_d   = 1'b1;
          if (is_wr_q) begin
            mem_we_s = 1'b1;
          end else begin
            rd_line_d = mem_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GNT: begin
        // Requests seen on the way out are picked up in the next IDLE cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_W'(0);
      is_wr_q   <= 1'b0;
      addr_q    <= {ADDR_LEN{1'b0}};
      wline_q   <= '{default: 32'h0000_0000};
      rd_line_q <= '{default: 32'h0000_0000};
      gnt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wline_q   <= wline_d;
      rd_line_q <= rd_line_d;
      gnt_q     <= gnt_d;
    end
  end

  // Line write commit on the edge that enters GNT.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= wline_q;
    end
  end

endmodule
